// File: rtl/sfft_peak_pkg.sv
// Shared types and default geometry for the SFFT peak finder.
package sfft_peak_pkg;

    localparam int PKG_DATA_W    = 32;
    localparam int PKG_NFFT      = 256;
    localparam int PKG_NUM_BANDS = 4;
    localparam int PKG_TIME_W    = 16;

    localparam int BAND_BINS = PKG_NFFT / (2 * PKG_NUM_BANDS);
    localparam int BIN_W     = $clog2(PKG_NFFT) - 1;
    localparam int BAND_W    = (PKG_NUM_BANDS > 1) ? $clog2(PKG_NUM_BANDS) : 1;

    typedef enum logic [1:0] {
        IDLE,
        SCAN,
        EMIT
    } state_t;

    typedef struct packed {
        logic [BIN_W-1:0]      bin;
        logic [PKG_DATA_W-1:0] mag;
        logic [BAND_W-1:0]     band;
        logic [PKG_TIME_W-1:0] frame_time;
        logic                  last;
    } peak_rec_t;

endpackage

// File: rtl/sfft_abs_sat.sv
// Combinational saturating absolute value: the most negative code maps to the
// largest positive code instead of wrapping back to itself.
module sfft_abs_sat #(
    parameter int DATA_W = 32
) (
    input  logic [DATA_W-1:0] x,
    output logic [DATA_W-1:0] mag
);

    localparam logic [DATA_W-1:0] MIN_NEG = {1'b1, {(DATA_W-1){1'b0}}};

    always_comb begin
        if (!x[DATA_W-1]) begin
            mag = x;
        end else if (x == MIN_NEG) begin
            mag = ~MIN_NEG;
        end else begin
            mag = -x;
        end
    end

endmodule

// File: rtl/sfft_peak_finder.sv
// Per-band peak picker over the lower half of an SFFT frame, streaming one
// record per band. Define SFFT_PEAK_THRESHOLD_EN to drop bands at or below peak_threshold.
module sfft_peak_finder
    import sfft_peak_pkg::*;
#(
    parameter int DATA_W    = 32,
    parameter int NFFT      = 256,
    parameter int NUM_BANDS = 4,
    parameter int TIME_W    = 16
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [DATA_W-1:0]       sfft_in [NFFT],
    input  logic                    sfft_valid,
`ifdef SFFT_PEAK_THRESHOLD_EN
    input  logic [DATA_W-1:0]       peak_threshold,
`endif
    output logic                    busy,
    output logic                    frame_dropped,
    output logic                    peak_valid,
    input  logic                    peak_ready,
    output logic [$clog2(NFFT)-2:0] peak_bin,
    output logic [DATA_W-1:0]       peak_mag,
    output logic [((NUM_BANDS > 1) ? $clog2(NUM_BANDS) : 1)-1:0] peak_band,
    output logic [TIME_W-1:0]       peak_time,
    output logic                    peak_last
);

    localparam int N_HALF      = NFFT / 2;
    localparam int L_BIN_W     = $clog2(NFFT) - 1;
    localparam int L_BAND_W    = (NUM_BANDS > 1) ? $clog2(NUM_BANDS) : 1;
    localparam int L_BAND_BINS = NFFT / (2 * NUM_BANDS);
    localparam int L_SHIFT     = $clog2(L_BAND_BINS);
    localparam int CNT_W       = L_BIN_W + 1;

    state_t               state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [L_BAND_W-1:0]  emit_q, emit_d;
    logic [TIME_W-1:0]    time_q, time_d;
    logic                 drop_q, drop_d;
    logic [DATA_W-1:0]    buf_q [N_HALF];
    logic [DATA_W-1:0]    buf_d [N_HALF];
    logic [DATA_W-1:0]    max_q [NUM_BANDS];
    logic [DATA_W-1:0]    max_d [NUM_BANDS];
    logic [L_BIN_W-1:0]   bin_q [NUM_BANDS];
    logic [L_BIN_W-1:0]   bin_d [NUM_BANDS];

    logic [NUM_BANDS-1:0] keep_mask;
    logic [L_BIN_W-1:0]   scan_idx;
    logic [L_BAND_W-1:0]  scan_band;
    logic [DATA_W-1:0]    abs_mag, scan_mag;
    logic                 has_next;
    logic [L_BAND_W-1:0]  next_band;
    logic                 unused_upper;

    assign scan_idx  = cnt_q[L_BIN_W-1:0];
    assign scan_band = L_BAND_W'(scan_idx >> L_SHIFT);

    sfft_abs_sat #(.DATA_W(DATA_W)) u_abs (
        .x   (buf_q[scan_idx]),
        .mag (abs_mag)
    );

    // DC carries no spectral peak information, so it never wins a band.
    assign scan_mag = (scan_idx == '0) ? '0 : abs_mag;

    always_comb begin
        has_next  = 1'b0;
        next_band = emit_q;
        for (int b = NUM_BANDS - 1; b >= 0; b--) begin
            if (b > int'(emit_q) && keep_mask[b]) begin
                has_next  = 1'b1;
                next_band = L_BAND_W'(b);
            end
        end
    end

    always_comb begin
        unused_upper = 1'b0;
        for (int i = N_HALF; i < NFFT; i++) begin
            unused_upper = unused_upper ^ (^sfft_in[i]);
        end
    end

`ifdef SFFT_PEAK_THRESHOLD_EN
    logic [NUM_BANDS-1:0] keep_q, keep_d, thresh_mask;
    logic                 has_first;
    logic [L_BAND_W-1:0]  first_band;

    assign keep_mask = keep_q;

    always_comb begin
        has_first  = 1'b0;
        first_band = '0;
        for (int b = NUM_BANDS - 1; b >= 0; b--) begin
            thresh_mask[b] = max_q[b] > peak_threshold;
            if (thresh_mask[b]) begin
                has_first  = 1'b1;
                first_band = L_BAND_W'(b);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) keep_q <= '0;
        else       keep_q <= keep_d;
    end
`else
    assign keep_mask = '1;
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        emit_d  = emit_q;
        time_d  = time_q;
        buf_d   = buf_q;
        max_d   = max_q;
        bin_d   = bin_q;
        drop_d  = sfft_valid && (state_q != IDLE);
`ifdef SFFT_PEAK_THRESHOLD_EN
        keep_d  = keep_q;
`endif
        case (state_q)
            IDLE: begin
                if (sfft_valid) begin
                    for (int i = 0; i < N_HALF; i++) buf_d[i] = sfft_in[i];
                    for (int b = 0; b < NUM_BANDS; b++) begin
                        max_d[b] = '0;
                        bin_d[b] = L_BIN_W'(b * L_BAND_BINS);
                    end
                    cnt_d   = '0;
                    emit_d  = '0;
                    state_d = SCAN;
                end
            end
            SCAN: begin
                cnt_d = cnt_q + 1'b1;
                // Strict compare keeps the lowest bin on ties.
                if ((int'(cnt_q) < N_HALF) && (scan_mag > max_q[scan_band])) begin
                    max_d[scan_band] = scan_mag;
                    bin_d[scan_band] = scan_idx;
                end
`ifdef SFFT_PEAK_THRESHOLD_EN
                if (int'(cnt_q) == N_HALF) begin
                    keep_d = thresh_mask;
                    if (has_first) begin
                        emit_d  = first_band;
                        state_d = EMIT;
                    end else begin
                        time_d  = time_q + 1'b1;
                        state_d = IDLE;
                    end
                end
`else
                if (int'(cnt_q) == N_HALF - 1) begin
                    emit_d  = '0;
                    state_d = EMIT;
                end
`endif
            end
            EMIT: begin
                if (peak_ready) begin
                    if (has_next) begin
                        emit_d = next_band;
                    end else begin
                        time_d  = time_q + 1'b1;
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            emit_q  <= '0;
            time_q  <= '0;
            drop_q  <= 1'b0;
            for (int b = 0; b < NUM_BANDS; b++) begin
                max_q[b] <= '0;
                bin_q[b] <= '0;
            end
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            emit_q  <= emit_d;
            time_q  <= time_d;
            drop_q  <= drop_d;
            max_q   <= max_d;
            bin_q   <= bin_d;
        end
    end

    always_ff @(posedge clk) begin
        buf_q <= buf_d;
    end

    assign busy          = (state_q != IDLE);
    assign frame_dropped = drop_q;
    assign peak_valid    = (state_q == EMIT);
    assign peak_last     = peak_valid && !has_next;
    assign peak_bin      = peak_valid ? bin_q[emit_q] : '0;
    assign peak_mag      = peak_valid ? max_q[emit_q] : '0;
    assign peak_band     = peak_valid ? emit_q : '0;
    assign peak_time     = time_q;

endmodule

// File: tb/tb_sfft_peak_finder.sv
// Scoreboard bench for sfft_peak_finder: directed frames push expected records,
// a negedge monitor pops and compares every accepted record.
module tb_sfft_peak_finder;
    import sfft_peak_pkg::*;

    localparam int NFFT = 256;
    localparam int NB   = 4;
    localparam int DW   = 32;
    localparam int TW   = 16;
`ifdef SFFT_PEAK_THRESHOLD_EN
    localparam int LAT = NFFT / 2 + 1;
`else
    localparam int LAT = NFFT / 2;
`endif

    logic            clk = 1'b0;
    logic            reset = 1'b1;
    logic [DW-1:0]   sfft_in [NFFT];
    logic            sfft_valid = 1'b0;
    logic            peak_ready = 1'b1;
    logic            busy, frame_dropped, peak_valid, peak_last;
    logic [BIN_W-1:0]  peak_bin;
    logic [DW-1:0]     peak_mag;
    logic [BAND_W-1:0] peak_band;
    logic [TW-1:0]     peak_time;
`ifdef SFFT_PEAK_THRESHOLD_EN
    logic [DW-1:0]   peak_threshold = '0;
`endif

    always #5 clk = ~clk;

    sfft_peak_finder #(.DATA_W(DW), .NFFT(NFFT), .NUM_BANDS(NB), .TIME_W(TW)) dut (
        .clk            (clk),
        .reset          (reset),
        .sfft_in        (sfft_in),
        .sfft_valid     (sfft_valid),
`ifdef SFFT_PEAK_THRESHOLD_EN
        .peak_threshold (peak_threshold),
`endif
        .busy           (busy),
        .frame_dropped  (frame_dropped),
        .peak_valid     (peak_valid),
        .peak_ready     (peak_ready),
        .peak_bin       (peak_bin),
        .peak_mag       (peak_mag),
        .peak_band      (peak_band),
        .peak_time      (peak_time),
        .peak_last      (peak_last)
    );

    peak_rec_t       exp_q [$];
    int              tests = 0;
    int              fails = 0;
    int              drop_cnt = 0;
    logic [TW-1:0]   exp_time = '0;
    logic [BIN_W-1:0] e_bin [NB];
    logic [DW-1:0]    e_mag [NB];

    task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic bit band_kept(input int b);
`ifdef SFFT_PEAK_THRESHOLD_EN
        return e_mag[b] > peak_threshold;
`else
        return (b >= 0);
`endif
    endfunction

    // Model: emit kept bands in ascending order, last flag on the highest kept one.
    task automatic push_expected(output int kept);
        int last_b;
        peak_rec_t r;
        kept   = 0;
        last_b = -1;
        for (int b = 0; b < NB; b++) if (band_kept(b)) begin kept++; last_b = b; end
        for (int b = 0; b < NB; b++) begin
            if (band_kept(b)) begin
                r.bin        = e_bin[b];
                r.mag        = e_mag[b];
                r.band       = BAND_W'(b);
                r.frame_time = exp_time;
                r.last       = (b == last_b);
                exp_q.push_back(r);
            end
        end
    endtask

    task automatic clear_frame();
        for (int i = 0; i < NFFT; i++) sfft_in[i] = '0;
    endtask

    task automatic apply_stimulus();
        @(posedge clk); #1 sfft_valid = 1'b1;
        @(posedge clk); #1 sfft_valid = 1'b0;
    endtask

    task automatic wait_drain(input string name);
        int n = 0;
        while ((exp_q.size() != 0 || busy) && n < 2000) begin
            @(posedge clk); #1;
            n++;
        end
        check_output({name, "_drain_timeout"}, 64'(n >= 2000), 64'd0);
    endtask

    peak_rec_t got, held;
    bit        hold_ok = 1'b0;

    always @(negedge clk) begin
        if (reset) begin
            hold_ok = 1'b0;
        end else begin
            got.bin        = peak_bin;
            got.mag        = peak_mag;
            got.band       = peak_band;
            got.frame_time = peak_time;
            got.last       = peak_last;
            if (hold_ok) check_output("hold_stable", {5'd0, peak_valid, got}, {5'd0, 1'b1, held});
            if (peak_valid && peak_ready) begin
                if (exp_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("[TB] FAIL unexpected_record: got %0h expected none", got);
                end else begin
                    check_output("record", 64'(got), 64'(exp_q.pop_front()));
                end
            end
            hold_ok = peak_valid && !peak_ready;
            held    = got;
            if (frame_dropped) drop_cnt++;
        end
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: got timeout expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int kept, n, d0;
        clear_frame();
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_output("rst_busy",    64'(busy), 0);
        check_output("rst_drop",    64'(frame_dropped), 0);
        check_output("rst_valid",   64'(peak_valid), 0);
        check_output("rst_last",    64'(peak_last), 0);
        check_output("rst_bin",     64'(peak_bin), 0);
        check_output("rst_mag",     64'(peak_mag), 0);
        check_output("rst_band",    64'(peak_band), 0);
        check_output("rst_time",    64'(peak_time), 0);
        reset = 1'b0;

        // Single spike, also measures latency with ready tied high.
        clear_frame();
        sfft_in[10] = 32'd1000;
        e_bin = '{7'd10, 7'd32, 7'd64, 7'd96};
        e_mag = '{32'd1000, 32'd0, 32'd0, 32'd0};
        push_expected(kept);
        exp_time++;
        apply_stimulus();
        n = 0;
        while (!peak_valid && n < 400) begin @(posedge clk); #1; n++; end
        check_output("first_valid_cycle", 64'(n), 64'(LAT));
        while (busy && n < 800) begin @(posedge clk); #1; n++; end
        check_output("ready_again_cycle", 64'(n), 64'(LAT + kept));
        wait_drain("spike");

        // Saturation, negative bin, DC suppression, with backpressure.
        clear_frame();
        sfft_in[0]  = 32'd9999;
        sfft_in[40] = 32'h8000_0000;
        sfft_in[41] = 32'hFFFF_FFFB;
        e_bin = '{7'd0, 7'd40, 7'd64, 7'd96};
        e_mag = '{32'd0, 32'h7FFF_FFFF, 32'd0, 32'd0};
        push_expected(kept);
        exp_time++;
        peak_ready = 1'b0;
        apply_stimulus();
        n = 0;
        while (!peak_valid && n < 400) begin @(posedge clk); #1; n++; end
        check_output("bp_valid_timeout", 64'(n >= 400), 0);
        repeat (5) @(posedge clk);
        #1 peak_ready = 1'b1;
        wait_drain("saturate");
        check_output("time_after_frames", 64'(peak_time), 64'(exp_time));

        // Ties plus a frame arriving while busy.
        clear_frame();
        sfft_in[70] = 32'hFFFF_FED4;
        sfft_in[80] = 32'hFFFF_FED4;
        e_bin = '{7'd0, 7'd32, 7'd70, 7'd96};
        e_mag = '{32'd0, 32'd0, 32'd300, 32'd0};
        push_expected(kept);
        exp_time++;
        d0 = drop_cnt;
        apply_stimulus();
        repeat (19) @(posedge clk);
        #1;
        sfft_in[100] = 32'd5000;
        sfft_valid = 1'b1;
        @(posedge clk); #1 sfft_valid = 1'b0;
        wait_drain("tie_drop");
        check_output("drop_pulses", 64'(drop_cnt - d0), 1);

        // Reset mid-scan, then a fresh frame.
        clear_frame();
        sfft_in[50] = 32'd777;
        apply_stimulus();
        repeat (30) @(posedge clk);
        #1 reset = 1'b1;
        exp_q.delete();
        exp_time = '0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        check_output("abort_busy",  64'(busy), 0);
        check_output("abort_valid", 64'(peak_valid), 0);
        clear_frame();
        sfft_in[96]  = 32'd123;
        sfft_in[127] = 32'd123;
        e_bin = '{7'd0, 7'd32, 7'd64, 7'd96};
        e_mag = '{32'd0, 32'd0, 32'd0, 32'd123};
        push_expected(kept);
        exp_time++;
        apply_stimulus();
        wait_drain("after_reset");

`ifdef SFFT_PEAK_THRESHOLD_EN
        peak_threshold = 32'd500;
        clear_frame();
        sfft_in[5]  = 32'd1000;
        sfft_in[40] = 32'd200;
        sfft_in[70] = 32'd600;
        e_bin = '{7'd5, 7'd40, 7'd70, 7'd96};
        e_mag = '{32'd1000, 32'd200, 32'd600, 32'd0};
        push_expected(kept);
        exp_time++;
        check_output("threshold_kept", 64'(kept), 2);
        apply_stimulus();
        wait_drain("threshold");
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/sfft_peak_finder.md
Name: sfft_peak_finder

Overview:
- Sits directly downstream of the SFFT pipeline and consumes its frame of NFFT real bins plus the one-cycle output-valid pulse.
- Reduces each frame to one peak (bin index, magnitude) per frequency band over the lower half spectrum.
- Stamps each peak with a frame time index and emits the records one at a time over a valid/ready stream to the fingerprint hasher.

Parameters:
- DATA_W, 32: bin width; equals SFFT output width; two's complement.
- NFFT, 256: FFT points; power of 2, ≥ 8. Only bins 0..NFFT/2-1 are used.
- NUM_BANDS, 4: band count; power of 2, ≤ NFFT/4. Each band is BAND_BINS = NFFT/(2*NUM_BANDS) bins wide.
- TIME_W, 16: width of the frame time counter.

Ports:
- clk, in, 1: clock.
- reset, in, 1: reset; synchronous, active-high.
- sfft_in, in, DATA_W x NFFT (unpacked array): SFFT real outputs; sampled only in the sfft_valid cycle.
- sfft_valid, in, 1: one-cycle frame strobe.
- busy, out, 1: high in any state other than IDLE.
- frame_dropped, out, 1: one-cycle pulse when a frame arrives while busy.
- peak_valid, out, 1: a peak record is presented.
- peak_ready, in, 1: consumer accepts the record.
- peak_bin, out, log2(NFFT)-1: absolute bin index of the peak.
- peak_mag, out, DATA_W: saturated magnitude of the peak.
- peak_band, out, log2(NUM_BANDS) (minimum 1): band number.
- peak_time, out, TIME_W: frame index.
- peak_last, out, 1: marks the final record of the frame.

Behaviour:
- Reset values: state=IDLE; busy=0, frame_dropped=0, peak_valid=0, peak_last=0; peak_bin, peak_mag, peak_band=0; frame time=0; band registers cleared.
- Reset asserted mid-scan or mid-emit aborts the frame; no partial records are emitted.
- FSM IDLE:
  - sfft_valid=1 latches bins 0..NFFT/2-1 into a local buffer.
  - Clears every band max to 0 and its bin to the band's first bin. Clears the scan counter.
  - Next state SCAN.
- FSM SCAN, one bin per cycle, counter 0..NFFT/2-1:
  - mag = |x|. 0x8000..0 saturates to 0x7FFF..F. Bin 0 (DC) is forced to mag 0.
  - band = counter >> log2(BAND_BINS).
  - Band max is updated only if mag > current max (strict). Ties keep the lower bin.
  - After counter NFFT/2-1, next state EMIT.
- FSM EMIT: presents bands 0..NUM_BANDS-1 in order.
  - peak_valid stays high and the record is held stable until peak_valid & peak_ready.
  - peak_last=1 on the final record.
  - Acceptance of the last record increments the frame time (wraps at 2^TIME_W) and returns to IDLE; busy falls in the same edge.
- Latency: with sfft_valid high in cycle 0 and peak_ready tied high:
  - first peak_valid in cycle NFFT/2+1;
  - records in consecutive cycles;
  - the block is ready for a new frame in cycle NFFT/2+1+NUM_BANDS.
- Frame dropping:
  - sfft_valid while busy: frame ignored, frame_dropped pulses, frame time unchanged.
  - sfft_valid in the same cycle as the final acceptance is also dropped, because the state is not yet IDLE.
- Frame time counts accepted frames only.
- Arithmetic: magnitude compare is unsigned DATA_W. No rounding. Stored bin index is absolute, not band-relative.

Optional Feature:
- Macro: SFFT_PEAK_THRESHOLD_EN.
- With the macro defined:
  - Adds input port peak_threshold (DATA_W, unsigned).
  - At SCAN end a keep mask is registered. A band is kept iff max > peak_threshold.
  - EMIT presents only kept bands, in ascending order. peak_last marks the highest kept band.
  - If no band is kept, the FSM goes SCAN→IDLE with no records, and frame time still increments.
  - Adds one cycle (mask registration) before the first peak_valid.
- Without the macro: no port; all NUM_BANDS bands are always emitted; latency as above.

Decomposition:
- Package sfft_peak_pkg:
  - peak_rec_t packed struct {bin, mag, band, time, last};
  - state enum {IDLE, SCAN, EMIT};
  - localparams BAND_BINS, BIN_W, BAND_W derived from NFFT/NUM_BANDS.
- One sub-module, sfft_abs_sat: combinational saturating absolute value, DATA_W parameter. Unit-testable standalone.

Test Plan:
- Single spike: bin 10=+1000, all other bins 0 (NFFT=256, 4 bands) → 4 records:
  - band0 {bin 10, mag 1000};
  - bands1..3 {bin 32/64/96, mag 0};
  - time 0, peak_last only on band3.
- Negative and saturation: bin 40=0x80000000, bin 41=-5 → band1 {bin 40, mag 0x7FFFFFFF}. Bin 0=+9999 is never reported (DC forced to 0).
- Ties: bins 70 and 80 both equal -300 → band2 reports bin 70, mag 300.
- Backpressure: peak_ready low for 5 cycles at the first record → record held stable, no loss; frame time becomes 1 after the last accept.
- Drop: second sfft_valid 20 cycles after the first → frame_dropped 1-cycle pulse; records still carry time 0.
- Reset during SCAN, then a fresh frame → no stale records; first record has time 0.
- With SFFT_PEAK_THRESHOLD_EN, threshold=500 and band maxima {1000, 200, 600, 0} → records for band0 and band2 only; band2 carries peak_last.
